hwregs: RTL

//  Memory-mapped hardware register block at 0xE000_0000-0xE000_FFFF, fed by the address decoder's
//  cpu_hwregs_req strobe. Owns board LEDs, 7-segment display, switch/key inputs, a free-running

---
 rtl/hwregs_pkg.sv | 24 ++
 rtl/uart_tx_shifter.sv | 88 ++++++++
 rtl/hwregs.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hwregs_pkg.sv
// Shared definitions for the hwregs block: register byte offsets and UART state encoding.
package hwregs_pkg;

    localparam logic [7:0] HWREG_LEDS     = 8'h00;
    localparam logic [7:0] HWREG_SEVENSEG = 8'h04;
    localparam logic [7:0] HWREG_SWITCHES = 8'h08;
    localparam logic [7:0] HWREG_TIMER    = 8'h0C;
    localparam logic [7:0] HWREG_UART_TX  = 8'h10;
    localparam logic [7:0] HWREG_UART_ST  = 8'h14;
    localparam logic [7:0] HWREG_UART_RX  = 8'h18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Counter width able to hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 serial transmitter: takes one byte per ready/valid handshake and shifts it out
// as start bit, eight data bits LSB first, stop bit, each DIV clocks long.
module uart_tx_shifter
    import hwregs_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int unsigned DW = cnt_width(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    uart_state_t   state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (div_q == DIV_LAST);
    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q != IDLE);
    assign tx_o    = tx_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = 1'b1;

        if (state_q != IDLE) begin
            div_d = bit_end ? '0 : div_q + DW'(1);
        end

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = START;
                    sh_d    = data_i;
                    div_d   = '0;
                    bit_d   = 3'd0;
                end
            end
            START: if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    sh_d  = {1'b0, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/hwregs.sv
// Memory-mapped board register block: LEDs, 7-seg, switches/keys, cycle timer, buffered UART TX.
// Optional 8N1 receiver on UART_RX when HWREGS_UART_RX_EN is defined.
module hwregs
    import hwregs_pkg::*;
#(
    parameter int unsigned CLOCK_HZ      = 50_000_000,
    parameter int unsigned BAUD          = 115_200,
    parameter int unsigned TX_FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_hwregs_req,
    input  logic [31:0] cpud_addr,
    input  logic        cpud_write,
    input  logic [3:0]  cpud_wstrb,
    input  logic [31:0] cpud_wdata,
    output logic        cpu_hwregs_ack,
    output logic [31:0] cpu_hwregs_rdata,
    output logic [9:0]  leds,
    output logic [23:0] seven_seg,
    input  logic [9:0]  switches,
    input  logic [3:0]  keys,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int unsigned DIV = (CLOCK_HZ / BAUD < 1) ? 1 : CLOCK_HZ / BAUD;
    localparam int unsigned AW  = cnt_width(TX_FIFO_DEPTH);

    logic [7:0] reg_off;
    logic       wr, rd;

    assign reg_off = {cpud_addr[7:2], 2'b00};
    assign wr      = cpu_hwregs_req &  cpud_write;
    assign rd      = cpu_hwregs_req & ~cpud_write;

    // ---------------- LEDs / 7-seg / input sync / timer ----------------
    logic [9:0]  leds_q;
    logic [23:0] seg_q;
    logic [9:0]  sw_s1_q, sw_s2_q;
    logic [3:0]  key_s1_q, key_s2_q;
    logic [31:0] timer_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            leds_q   <= '0;
            seg_q    <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_s1_q <= '1;
            key_s2_q <= '1;
            timer_q  <= '0;
        end else begin
            if (wr && reg_off == HWREG_LEDS) begin
                if (cpud_wstrb[0]) leds_q[7:0] <= cpud_wdata[7:0];
                if (cpud_wstrb[1]) leds_q[9:8] <= cpud_wdata[9:8];
            end
            if (wr && reg_off == HWREG_SEVENSEG) begin
                if (cpud_wstrb[0]) seg_q[7:0]   <= cpud_wdata[7:0];
                if (cpud_wstrb[1]) seg_q[15:8]  <= cpud_wdata[15:8];
                if (cpud_wstrb[2]) seg_q[23:16] <= cpud_wdata[23:16];
            end
            sw_s1_q  <= switches;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= keys;
            key_s2_q <= key_s1_q;
            timer_q  <= (wr && reg_off == HWREG_TIMER) ? 32'd0 : timer_q + 32'd1;
        end
    end

    assign leds      = leds_q;
    assign seven_seg = seg_q;

    // ---------------- UART TX FIFO ----------------
    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          fifo_empty, fifo_full, push_req, push_ok, pop;
    logic          tx_ready, tx_busy, ovf_q;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AW+1)'(TX_FIFO_DEPTH));
    assign push_req   = wr && reg_off == HWREG_UART_TX && cpud_wstrb[0];
    assign pop        = tx_ready && !fifo_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok    = push_req && (!fifo_full || pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= cpud_wdata[7:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (push_req && !push_ok)
                ovf_q <= 1'b1;
            else if (wr && reg_off == HWREG_UART_ST && cpud_wdata[1])
                ovf_q <= 1'b0;
        end
    end

    uart_tx_shifter #(.DIV(DIV)) u_tx (
        .clock   (clock),
        .reset_n (reset_n),
        .valid_i (!fifo_empty),
        .data_i  (fifo_mem[rd_ptr_q]),
        .ready_o (tx_ready),
        .busy_o  (tx_busy),
        .tx_o    (uart_tx)
    );

    // ---------------- optional UART RX ----------------
    logic [31:0] rx_word;
    logic        rx_overrun;

`ifdef HWREGS_UART_RX_EN
    localparam int unsigned CW = cnt_width(DIV);
    localparam logic [CW-1:0] RX_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] RX_HALF = CW'((DIV / 2 >= 1) ? DIV / 2 - 1 : 0);

    uart_state_t   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_div_q, rx_div_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d, rx_hold_q;
    logic          rx_s1_q, rx_s2_q, rx_full_q, rx_ovr_q, rx_done, rx_rd;

    assign rx_rd = rd && reg_off == HWREG_UART_RX;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_div_d   = rx_div_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_div_d = '0;
                if (!rx_s2_q) rx_state_d = START;
            end
            // Re-check the start bit at its midpoint to reject glitches.
            START: begin
                if (rx_div_q == RX_HALF) begin
                    rx_div_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_div_q == RX_LAST) begin
                    rx_div_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = STOP;
                end
            end
            STOP: begin
                if (rx_div_q == RX_LAST) begin
                    rx_state_d = IDLE;
                    rx_done    = rx_s2_q;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= IDLE;
            rx_div_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
            rx_hold_q  <= 8'h00;
            rx_full_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            if (rx_done) begin
                rx_hold_q <= rx_sh_q;
                rx_full_q <= 1'b1;
                if (rx_full_q && !rx_rd) rx_ovr_q <= 1'b1;
            end else if (rx_rd) begin
                rx_full_q <= 1'b0;
            end
            if (wr && reg_off == HWREG_UART_ST && cpud_wdata[2]) rx_ovr_q <= 1'b0;
        end
    end

    assign rx_word    = rx_full_q ? {23'b0, 1'b1, rx_hold_q} : 32'hFFFF_FFFF;
    assign rx_overrun = rx_ovr_q;
`else
    logic unused_rx;
    assign unused_rx  = uart_rx;
    assign rx_word    = 32'hFFFF_FFFF;
    assign rx_overrun = 1'b0;
`endif

    // ---------------- read mux / ack ----------------
    logic [31:0] rdata_d, rdata_q;
    logic        ack_q;

    always_comb begin
        rdata_d = '0;
        case (reg_off)
            HWREG_LEDS:     rdata_d = {22'b0, leds_q};
            HWREG_SEVENSEG: rdata_d = {8'b0, seg_q};
            HWREG_SWITCHES: rdata_d = {12'b0, ~key_s2_q, 6'b0, sw_s2_q};
            HWREG_TIMER:    rdata_d = timer_q;
            HWREG_UART_TX:  rdata_d = 32'(TX_FIFO_DEPTH) - 32'(count_q);
            HWREG_UART_ST:  rdata_d = {29'b0, rx_overrun, ovf_q, tx_busy | !fifo_empty};
            HWREG_UART_RX:  rdata_d = rx_word;
            default:        rdata_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= cpu_hwregs_req;
            rdata_q <= rd ? rdata_d : 32'd0;
        end
    end

    assign cpu_hwregs_ack   = ack_q;
    assign cpu_hwregs_rdata = rdata_q;

    logic unused_bits;
    assign unused_bits = ^{cpud_addr[31:8], cpud_addr[1:0], cpud_wstrb[3], cpud_wdata[31:24]};

endmodule
